rect_fill_engine: RTL and testbench
===================================

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter H_RES, default 640, frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, frame height in pixels.
REQ-003 SHALL have parameter COLOR_W, default 24, pixel data width.
REQ-004 SHALL have parameter COORD_W, default 10, coordinate/extent width.
REQ-005 SHALL have parameter ADDR_W, default 19, framebuffer address width (>= clog2(H_RES*V_RES)).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port cmd_valid  input  1  command present.
REQ-009 SHALL have port cmd_ready  output  1  engine accepts command this cycle.
REQ-010 SHALL have ports cmd_x0, cmd_y0  input  COORD_W  rectangle top-left corner.
REQ-011 SHALL have ports cmd_w, cmd_h  input  COORD_W  rectangle extent in pixels.
REQ-012 SHALL have port cmd_color  input  COLOR_W  fill colour.
REQ-013 SHALL have port cmd_mode  input  1  0 = rectangle fill, 1 = full-frame clear (coordinates ignored).
REQ-014 SHALL have port fb_stall  input  1  framebuffer back-pressure; write not taken while high.
REQ-015 SHALL have ports fb_we  output  1, fb_waddr  output  ADDR_W, fb_wdata  output  COLOR_W  framebuffer write port.
REQ-016 SHALL have port busy  output  1  command in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port pix_count  output  ADDR_W+1  writes taken for the current/last command.

Function
REQ-019 SHALL implement states IDLE, SETUP, FILL, DONE; IDLE->SETUP on cmd_valid&&cmd_ready; SETUP->FILL if clipped area nonzero, else SETUP->DONE; FILL->DONE after last write taken; DONE->IDLE unconditionally.
REQ-020 SHALL drive cmd_ready high only in IDLE; command fields SHALL be registered at acceptance, inputs ignored afterward.
REQ-021 SHALL in SETUP clip: xe = min(x0+w, H_RES), ye = min(y0+h, V_RES), sums computed at COORD_W+1 bits; area empty if x0>=H_RES, y0>=V_RES, w==0 or h==0.
REQ-022 SHALL in mode 1 use x0=y0=0, xe=H_RES, ye=V_RES regardless of cmd fields.
REQ-023 SHALL assert fb_we on every FILL cycle, first write the cycle after SETUP (accept at N -> first fb_we at N+2).
REQ-024 SHALL scan row-major: x from x0 to xe-1, then y+1; fb_waddr = y*H_RES + x, generated incrementally (row base += H_RES), no multiplier in the per-pixel path.
REQ-025 SHALL hold fb_we, fb_waddr, fb_wdata stable while fb_stall is high and advance only on cycles with fb_we && !fb_stall.
REQ-026 SHALL drive fb_wdata = registered colour throughout the command.
REQ-027 SHALL clear pix_count at acceptance and increment it once per taken write; value holds after done until next acceptance.
REQ-028 SHALL assert busy in SETUP, FILL, DONE; done high exactly one cycle, in DONE.
REQ-029 SHALL leave fb_we low outside FILL.

Reset
REQ-030 SHALL on rst_n low at a clock edge enter IDLE and set fb_we=0, busy=0, done=0, pix_count=0, fb_waddr=0, fb_wdata=0, cmd_ready=0 during reset and 1 the first cycle after release.
REQ-031 SHALL abort any in-progress command on reset with no further writes and no done pulse.

Structure
REQ-032 SHALL place state enum and default resolution constants in shared package gpu_pkg.
REQ-033 SHALL contain one sub-module, rect_clip, computing clipped bounds and empty flag combinationally.

Verification
REQ-034 SHALL cover: rect (270,190,100,100,ff0000) no stall -> 10000 writes, first addr 121870, last 185329, done 10002 cycles after accept, pix_count 10000.
REQ-035 SHALL cover: rect (600,470,100,20) -> 40x10 = 400 writes, last addr 307199, no address >= 307200.
REQ-036 SHALL cover: w=0, and separately x0=700 -> no fb_we, done 2 cycles after accept, pix_count 0.
REQ-037 SHALL cover: random fb_stall 30% during 8x8 rect at (0,0) -> exactly 64 distinct taken addresses in order, outputs stable across stalls.
REQ-038 SHALL cover: mode 1 colour 000000 -> 307200 writes covering 0..307199 once each.
REQ-039 SHALL cover: rst_n low after 50 writes -> fb_we low next cycle, no done, cmd_ready 1 after release, next command runs correctly.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the fill engine: the control state encoding and
// the default frame geometry used as parameter defaults.
package gpu_pkg;

    // Control states of the rectangle fill engine.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    // Default frame geometry and datapath widths.
    localparam int DEF_H_RES   = 640;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_COLOR_W = 24;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_ADDR_W  = 19;

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a rectangle command against the frame.
// Produces an inclusive start corner, exclusive end corner and an
// empty flag. Mode 1 (full-frame clear) ignores the command geometry.
module rect_clip
    import gpu_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               mode,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [COORD_W:0]   clip_x0,
    output logic [COORD_W:0]   clip_y0,
    output logic [COORD_W:0]   clip_xe,
    output logic [COORD_W:0]   clip_ye,
    output logic               empty
);

    localparam int CW1 = COORD_W + 1;

    // Frame limits at the widened coordinate width so the end-corner sums
    // can be compared without overflow.
    localparam logic [COORD_W:0] H_LIM = CW1'(H_RES);
    localparam logic [COORD_W:0] V_LIM = CW1'(V_RES);

    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;
    logic [COORD_W:0] x_sum;
    logic [COORD_W:0] y_sum;

    // Clip the end corner to the frame and flag rectangles with no pixels.
    always_comb begin
        x_ext   = {1'b0, x0};
        y_ext   = {1'b0, y0};
        x_sum   = x_ext + {1'b0, w};
        y_sum   = y_ext + {1'b0, h};
        clip_x0 = '0;
        clip_y0 = '0;
        clip_xe = H_LIM;
        clip_ye = V_LIM;
        empty   = 1'b0;
        if (!mode) begin
            clip_x0 = x_ext;
            clip_y0 = y_ext;
            clip_xe = (x_sum > H_LIM) ? H_LIM : x_sum;
            clip_ye = (y_sum > V_LIM) ? V_LIM : y_sum;
            empty   = (x_ext >= H_LIM) || (y_ext >= V_LIM) ||
                      (w == '0) || (h == '0);
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill / frame clear engine. Accepts one command at a time,
// clips it against the frame, then streams one framebuffer write per
// cycle in row-major order, honouring framebuffer back-pressure.
module rect_fill_engine
    import gpu_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_mode,
    input  logic               fb_stall,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_waddr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    pix_count
);

    // Typed increments and the per-row address stride.
    localparam logic [COORD_W:0] ONE_C  = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_P = 1;
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    fill_state_t state;

    // Command fields captured at acceptance.
    logic [COORD_W-1:0] x0_reg;
    logic [COORD_W-1:0] y0_reg;
    logic [COORD_W-1:0] w_reg;
    logic [COORD_W-1:0] h_reg;
    logic               mode_reg;

    // Scan bounds and position of the pending write.
    logic [COORD_W:0]  x_start_reg;
    logic [COORD_W:0]  x_end_reg;
    logic [COORD_W:0]  y_end_reg;
    logic [COORD_W:0]  x_reg;
    logic [COORD_W:0]  y_reg;
    logic [ADDR_W-1:0] row_base_reg;

    // Clipper results, valid while in SETUP.
    logic [COORD_W:0] clip_x0;
    logic [COORD_W:0] clip_y0;
    logic [COORD_W:0] clip_xe;
    logic [COORD_W:0] clip_ye;
    logic             clip_empty;

    logic [ADDR_W-1:0] setup_base;
    logic [ADDR_W-1:0] next_row_base;
    logic              x_last;
    logic              y_last;

    rect_clip #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_clip (
        .mode    (mode_reg),
        .x0      (x0_reg),
        .y0      (y0_reg),
        .w       (w_reg),
        .h       (h_reg),
        .clip_x0 (clip_x0),
        .clip_y0 (clip_y0),
        .clip_xe (clip_xe),
        .clip_ye (clip_ye),
        .empty   (clip_empty)
    );

    // The only multiply is the starting row base, used once per command
    // in SETUP; the per-pixel path below only adds.
    assign setup_base    = ADDR_W'(clip_y0) * H_STEP;
    assign next_row_base = row_base_reg + H_STEP;
    assign x_last        = (x_reg + ONE_C) == x_end_reg;
    assign y_last        = (y_reg + ONE_C) == y_end_reg;

    // Command FSM with registered handshake, status and write-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fb_we        <= 1'b0;
            fb_waddr     <= '0;
            fb_wdata     <= '0;
            pix_count    <= '0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            mode_reg     <= 1'b0;
            x_start_reg  <= '0;
            x_end_reg    <= '0;
            y_end_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            row_base_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    done      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        x0_reg    <= cmd_x0;
                        y0_reg    <= cmd_y0;
                        w_reg     <= cmd_w;
                        h_reg     <= cmd_h;
                        mode_reg  <= cmd_mode;
                        fb_wdata  <= cmd_color;
                        pix_count <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // Load scan bounds and present the first write directly.
                    x_start_reg  <= clip_x0;
                    x_end_reg    <= clip_xe;
                    y_end_reg    <= clip_ye;
                    x_reg        <= clip_x0;
                    y_reg        <= clip_y0;
                    row_base_reg <= setup_base;
                    fb_waddr     <= setup_base + ADDR_W'(clip_x0);
                    if (clip_empty) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        fb_we <= 1'b1;
                        state <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    // Advance only when the presented write is taken.
                    if (!fb_stall) begin
                        pix_count <= pix_count + ONE_P;
                        if (x_last) begin
                            if (y_last) begin
                                fb_we <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                x_reg        <= x_start_reg;
                                y_reg        <= y_reg + ONE_C;
                                row_base_reg <= next_row_base;
                                fb_waddr     <= next_row_base + ADDR_W'(x_start_reg);
                            end
                        end else begin
                            x_reg    <= x_reg + ONE_C;
                            fb_waddr <= fb_waddr + ONE_A;
                        end
                    end
                end

                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed and randomized fill commands checked
// against a pixel-list reference model built from the clipping rules.
module tb_rect_fill_engine;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int CW  = 10;
    localparam int AW  = 19;
    localparam int COLW = 24;
    // Reduced-geometry instance so a full-frame clear fits a short run.
    localparam int HS  = 40;
    localparam int VS  = 30;
    localparam int CWS = 6;
    localparam int AWS = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            cmd_valid, cmd_ready, cmd_mode, fb_stall;
    logic [CW-1:0]   cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [COLW-1:0] cmd_color;
    logic            fb_we, busy, done;
    logic [AW-1:0]   fb_waddr;
    logic [COLW-1:0] fb_wdata;
    logic [AW:0]     pix_count;

    logic            cmd_valid_s, cmd_ready_s, cmd_mode_s, fb_stall_s;
    logic [CWS-1:0]  cmd_x0_s, cmd_y0_s, cmd_w_s, cmd_h_s;
    logic [COLW-1:0] cmd_color_s;
    logic            fb_we_s, busy_s, done_s;
    logic [AWS-1:0]  fb_waddr_s;
    logic [COLW-1:0] fb_wdata_s;
    logic [AWS:0]    pix_count_s;

    rect_fill_engine #(
        .H_RES(H), .V_RES(V), .COLOR_W(COLW), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .cmd_mode(cmd_mode), .fb_stall(fb_stall),
        .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
        .busy(busy), .done(done), .pix_count(pix_count)
    );

    rect_fill_engine #(
        .H_RES(HS), .V_RES(VS), .COLOR_W(COLW), .COORD_W(CWS), .ADDR_W(AWS)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
        .cmd_x0(cmd_x0_s), .cmd_y0(cmd_y0_s), .cmd_w(cmd_w_s), .cmd_h(cmd_h_s),
        .cmd_color(cmd_color_s), .cmd_mode(cmd_mode_s), .fb_stall(fb_stall_s),
        .fb_we(fb_we_s), .fb_waddr(fb_waddr_s), .fb_wdata(fb_wdata_s),
        .busy(busy_s), .done(done_s), .pix_count(pix_count_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: list of frame addresses a command must write, in order.
    int exp_q[$];
    task automatic build_expect(input int hres, input int vres, input int x0, input int y0,
                                input int w, input int h, input logic mode);
        int xs, ys, xe, ye;
        exp_q.delete();
        if (mode) begin
            xs = 0; ys = 0; xe = hres; ye = vres;
        end else begin
            if (x0 >= hres || y0 >= vres || w == 0 || h == 0) return;
            xs = x0; ys = y0;
            xe = (x0 + w < hres) ? x0 + w : hres;
            ye = (y0 + h < vres) ? y0 + h : vres;
        end
        for (int y = ys; y < ye; y++)
            for (int x = xs; x < xe; x++)
                exp_q.push_back(y * hres + x);
    endtask

    // Write-port observers: record taken writes, colour errors, stall stability, done pulses.
    int got_q[$];
    int got_s[$];
    int done_cnt = 0, done_edge = 0, done_cnt_s = 0, done_edge_s = 0;
    int color_err = 0, stable_err = 0, color_err_s = 0;
    logic [COLW-1:0] cur_color = '0;
    logic            prev_hold = 1'b0;
    logic [AW-1:0]   prev_addr;
    logic [COLW-1:0] prev_data;

    always @(negedge clk) begin
        if (prev_hold && (fb_we !== 1'b1 || fb_waddr !== prev_addr || fb_wdata !== prev_data))
            stable_err++;
        prev_hold = (fb_we === 1'b1) && (fb_stall === 1'b1);
        prev_addr = fb_waddr;
        prev_data = fb_wdata;
        if (fb_we === 1'b1 && fb_stall === 1'b0) begin
            got_q.push_back(int'(fb_waddr));
            if (fb_wdata !== cur_color) color_err++;
        end
        if (done === 1'b1) begin done_cnt++; done_edge = cyc + 1; end
        if (fb_we_s === 1'b1 && fb_stall_s === 1'b0) begin
            got_s.push_back(int'(fb_waddr_s));
            if (fb_wdata_s !== '0) color_err_s++;
        end
        if (done_s === 1'b1) begin done_cnt_s++; done_edge_s = cyc + 1; end
    end

    task automatic issue_main(input int x0, input int y0, input int w, input int h,
                              input logic [COLW-1:0] color, input logic mode, output int acc);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(posedge clk); #2; k++; end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        got_q.delete();
        color_err = 0; stable_err = 0; cur_color = color;
        cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_w = CW'(w); cmd_h = CW'(h);
        cmd_color = color; cmd_mode = mode; cmd_valid = 1'b1;
        @(posedge clk); #2;
        acc = cyc;
        cmd_valid = 1'b0;
        // Garbage on the command bus after acceptance must be ignored.
        cmd_x0 = CW'($urandom); cmd_y0 = CW'($urandom); cmd_w = CW'($urandom);
        cmd_h = CW'($urandom); cmd_color = COLW'($urandom); cmd_mode = ~mode;
        check("pix_count_cleared", pix_count, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic run_main(input string tag, input int x0, input int y0, input int w, input int h,
                            input logic [COLW-1:0] color, input logic mode, input int stall_pct);
        int acc, k, start_done, mism, n;
        start_done = done_cnt;
        issue_main(x0, y0, w, h, color, mode, acc);
        build_expect(H, V, x0, y0, w, h, mode);
        k = 0;
        while (done_cnt == start_done && k < exp_q.size() * 5 + 100) begin
            fb_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            @(posedge clk); #2;
            k++;
        end
        fb_stall = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        check({tag, "_done_pulses"}, done_cnt - start_done, 1);
        if (stall_pct == 0) check({tag, "_done_latency"}, done_edge - acc, exp_q.size() + 2);
        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) mism++;
        check({tag, "_addr_order"}, mism, 0);
        check({tag, "_wdata"}, color_err, 0);
        check({tag, "_stall_hold"}, stable_err, 0);
        check({tag, "_pix_count"}, pix_count, exp_q.size());
        check({tag, "_busy_idle"}, busy, 0);
        $display("cmd %s x0=%0d y0=%0d w=%0d h=%0d mode=%0d stall=%0d%% writes=%0d", tag, x0, y0, w, h,
                 mode, stall_pct, got_q.size());
    endtask

    initial begin
        int acc, k, start_done, n_after, mism, mx;
        bit seen[HS*VS];
        rst_n = 1'b0;
        cmd_valid = 0; cmd_mode = 0; fb_stall = 0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        cmd_valid_s = 0; cmd_mode_s = 1; fb_stall_s = 0;
        cmd_x0_s = CWS'($urandom); cmd_y0_s = CWS'($urandom);
        cmd_w_s = CWS'($urandom); cmd_h_s = CWS'($urandom); cmd_color_s = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_fb_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_fb_waddr", fb_waddr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("cmd_ready_after_release", cmd_ready, 1);

        // Large in-frame rectangle.
        run_main("big", 270, 190, 100, 100, 24'hff0000, 1'b0, 0);
        check("big_first_addr", (got_q.size() > 0) ? got_q[0] : -1, 121870);
        check("big_last_addr", (got_q.size() > 0) ? got_q[got_q.size()-1] : -1, 185329);

        // Corner-clipped rectangle.
        run_main("corner", 600, 470, 100, 20, 24'h00ff00, 1'b0, 0);
        mx = -1;
        foreach (got_q[i]) if (got_q[i] > mx) mx = got_q[i];
        check("corner_last_addr", (got_q.size() > 0) ? got_q[got_q.size()-1] : -1, 307199);
        check("corner_max_in_frame", (mx >= 0) && (mx < H * V), 1);

        // Empty commands.
        run_main("zero_w", 10, 10, 0, 5, 24'h0000ff, 1'b0, 0);
        run_main("off_right", 700, 10, 5, 5, 24'h00abcd, 1'b0, 0);

        // Back-pressure on a small rectangle.
        run_main("stall8x8", 0, 0, 8, 8, COLW'($urandom), 1'b0, 30);

        // Randomized rectangles, some under back-pressure.
        for (int t = 0; t < 6; t++)
            run_main($sformatf("rnd%0d", t), $urandom_range(700), $urandom_range(520),
                     $urandom_range(40), $urandom_range(30), COLW'($urandom), 1'b0,
                     (t % 2) ? 30 : 0);

        // Reset in the middle of a full-frame clear.
        start_done = done_cnt;
        issue_main(5, 5, 5, 5, 24'h123456, 1'b1, acc);
        k = 0;
        while (got_q.size() < 50 && k < 200) begin @(posedge clk); #2; k++; end
        check("abort_reached_50", got_q.size() >= 50, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        n_after = got_q.size();
        check("abort_fb_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_pix_count", pix_count, 0);
        check("abort_cmd_ready_low", cmd_ready, 0);
        repeat (2) begin @(posedge clk); #2; end
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("abort_cmd_ready_high", cmd_ready, 1);
        repeat (3) begin @(posedge clk); #2; end
        check("abort_no_more_writes", got_q.size(), n_after);
        check("abort_no_done", done_cnt, start_done);
        mism = 0;
        for (int i = 0; i < 50 && i < got_q.size(); i++) if (got_q[i] != i) mism++;
        check("abort_clear_order", mism, 0);
        $display("cmd abort mode=1 writes_before_reset=%0d", n_after);
        run_main("after_abort", 100, 50, 12, 7, 24'h5a5a5a, 1'b0, 0);

        // Full-frame clear on the reduced-geometry instance.
        k = 0;
        while (cmd_ready_s !== 1'b1 && k < 50) begin @(posedge clk); #2; k++; end
        got_s.delete(); color_err_s = 0; start_done = done_cnt_s;
        cmd_valid_s = 1'b1;
        @(posedge clk); #2;
        acc = cyc;
        cmd_valid_s = 1'b0;
        build_expect(HS, VS, 0, 0, 0, 0, 1'b1);
        k = 0;
        while (done_cnt_s == start_done && k < 3000) begin @(posedge clk); #2; k++; end
        repeat (3) begin @(posedge clk); #2; end
        check("clear_done_pulses", done_cnt_s - start_done, 1);
        check("clear_latency", done_edge_s - acc, HS * VS + 2);
        check("clear_write_count", got_s.size(), exp_q.size());
        mism = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < got_s.size(); i++) begin
            if (i >= exp_q.size() || got_s[i] != exp_q[i]) mism++;
            if (got_s[i] >= 0 && got_s[i] < HS * VS) begin
                if (seen[got_s[i]]) mism++;
                seen[got_s[i]] = 1'b1;
            end else mism++;
        end
        check("clear_addr_once_in_order", mism, 0);
        check("clear_wdata", color_err_s, 0);
        check("clear_pix_count", pix_count_s, HS * VS);
        $display("cmd clear_small mode=1 writes=%0d", got_s.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
